lsu: RTL and testbench

- Load/store unit between the RV32I multicycle core's execute stage and the single-port word memory (32-bit words, 1-cycle registered read, `mem_rw` low = write).
- Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW request at a time.
- Aligns load data and sign- or zero-extends it.
- Memory has no byte enables, so sub-word stores are done as read-modify-write.
- Returns a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_if.sv | 32 +++
 rtl/lsu_align.sv | 60 ++++++
 rtl/lsu.sv | 114 +++++++++++
 tb/tb_lsu.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and helpers for the load/store unit.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a. Contents: funct3 codes, access-size codes, FSM state type.
package lsu_pkg;

  // RV32I load funct3 codes
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  // RV32I store funct3 codes
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  // funct3[1:0] encodes the access size for both loads and stores
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Encoding errors that exist regardless of address alignment.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 > F3_SW);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: bundles the core-side request/response and memory-side signals.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready handshake; memory side has none (fixed timing).
// Modports: slave = the LSU itself, master = core plus memory environment.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: lane extraction with sign/zero extension, and sub-word store merge.
// Latency: combinational.
// Backpressure: none.
// Ports: funct3, lane (addr[1:0]), word (memory word), wdata (store data)
//        -> load_val (extended load result), merged (word to write back).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    // Only addr[1] picks a halfword; addr[0] is ignored when alignment is not enforced.
    half_sel = lane[1] ? word[31:16] : word[15:0];
    // funct3[2] marks the unsigned load variants
    sext = ~funct3[2];

    load_val = word;
    merged   = wdata;
    case (funct3[1:0])
      SZ_B: begin
        load_val = {{24{sext & byte_sel[7]}}, byte_sel};
        merged   = word;
        case (lane)
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          2'd3:    merged[31:24] = wdata[7:0];
          default: merged[7:0]   = wdata[7:0];
        endcase
      end
      SZ_H: begin
        load_val = {{16{sext & half_sel[15]}}, half_sel};
        merged   = word;
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: begin
        load_val = word;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit in front of a single-port word memory without byte enables.
// Latency (accept edge to rsp_valid): load 3, SW 2, SB/SH 4 (read-modify-write), error 1.
// Backpressure: req_ready only in IDLE; one request in flight; rsp is a 1-cycle pulse.
// Ports: clk, resetn (async active-low), bus (lsu_if.slave: req_*, rsp_*, mem_*).
// Build option: define LSU_MISALIGN_CHECK_EN to flag misaligned LH/LHU/SH/LW/SW as errors;
// without it the low address bits below the access size are ignored.
// Only DATA_W = 32 is supported.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)(
  input  logic  clk,
  input  logic  resetn,
  lsu_if.slave  bus
);

  state_t            state, state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              accept;
  logic              mis;
  logic              req_err;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  assign accept = bus.req_valid && (state == ST_IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = ((bus.req_funct3[1:0] == SZ_H) && bus.req_addr[0]) ||
               ((bus.req_funct3[1:0] == SZ_W) && (bus.req_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  assign req_err = f3_illegal(bus.req_we, bus.req_funct3) || mis;

  // One aligner serves both directions: load_val for loads, merged for SB/SH.
  lsu_align u_align (
    .funct3   (f3_q),
    .lane     (addr_q[1:0]),
    .word     (bus.mem_rdata),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                                  state_nxt = ST_DONE;
          else if (bus.req_we && bus.req_funct3 == F3_SW) state_nxt = ST_WR;
          else                                          state_nxt = ST_RD;
        end
      end
      ST_RD:      state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: state_nxt = we_q ? ST_WR : ST_DONE;
      ST_WR:      state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
        // Full-word stores write the store data as-is; sub-word merges overwrite this later.
        merge_q <= bus.req_wdata;
      end
      if (state == ST_RD_WAIT) begin
        if (we_q) merge_q <= merged;
        else      rdata_q <= load_val;
      end
    end
  end

  // Memory side is driven purely from state and latched request fields.
  assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata = merge_q;
  assign bus.mem_rw    = (state != ST_WR);

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_DONE);
  assign bus.rsp_err   = (state == ST_DONE) && err_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed, table-driven bench for lsu with a 1-cycle registered word memory model.
// Expectations follow LSU_MISALIGN_CHECK_EN when the macro is defined for the build.
module tb_lsu;
  import lsu_pkg::*;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        keep;    // rsp_rdata must hold the previous load result
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    logic [31:0] wword;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic preload = 1'b1;
  logic [31:0] mem [0:63];
  int checks = 0;
  int failures = 0;
  logic [31:0] last_exp = 32'h0;
  vec_t vecs [16];

  lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Single-port memory: write when mem_rw low, read data registered one cycle later.
  always @(posedge clk) begin
    if (preload) begin
      mem[16] <= 32'h8899AABB;
      mem[17] <= 32'h00000000;
    end else if (!bus.mem_rw) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr[7:2]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts cycles after the accept edge until rsp_valid (0 = budget expired).
  task automatic wait_rsp(output int lat, output int nwr, output logic [31:0] wd,
                          output int busy_rdy);
    lat = 0; nwr = 0; wd = 32'h0; busy_rdy = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (!bus.mem_rw) begin
        nwr++;
        wd = bus.mem_wdata;
      end
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
      if (bus.req_ready) busy_rdy++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, nwr, busy;
    logic [31:0] wd, exp_rd;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({tag, "_ready"}, bus.req_ready, 1'b1);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = 32'h0;
    wait_rsp(lat, nwr, wd, busy);
    exp_rd = v.keep ? last_exp : v.rdata;
    if (!v.keep) last_exp = v.rdata;
    chk({tag, "_lat"}, lat, v.lat);
    chk({tag, "_err"}, bus.rsp_err, v.err);
    chk({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
    chk({tag, "_nwr"}, nwr, v.nwr);
    if (v.nwr != 0) chk({tag, "_wword"}, wd, v.wword);
    chk({tag, "_busy_rdy"}, busy, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, {bus.rsp_valid, bus.req_ready}, 2'b01);
  endtask

  initial begin
    int lat, nwr, busy, wr_seen, rsp_seen;
    logic [31:0] wd;

    vecs[0]  = '{1'b0, 3'd0, 32'h41, 32'h0, 1'b0, 32'hFFFFFFAA, 1'b0, 3, 0, 32'h0};
    vecs[1]  = '{1'b0, 3'd5, 32'h42, 32'h0, 1'b0, 32'h00008899, 1'b0, 3, 0, 32'h0};
    vecs[2]  = '{1'b0, 3'd1, 32'h42, 32'h0, 1'b0, 32'hFFFF8899, 1'b0, 3, 0, 32'h0};
    vecs[3]  = '{1'b0, 3'd4, 32'h40, 32'h0, 1'b0, 32'h000000BB, 1'b0, 3, 0, 32'h0};
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[4]  = '{1'b0, 3'd2, 32'h42, 32'h0, 1'b1, 32'h0, 1'b1, 1, 0, 32'h0};
`else
    vecs[4]  = '{1'b0, 3'd2, 32'h42, 32'h0, 1'b0, 32'h8899AABB, 1'b0, 3, 0, 32'h0};
`endif
    vecs[5]  = '{1'b1, 3'd0, 32'h43, 32'hABCDEF12, 1'b1, 32'h0, 1'b0, 4, 1, 32'h1299AABB};
    vecs[6]  = '{1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'h1299AABB, 1'b0, 3, 0, 32'h0};
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[7]  = '{1'b0, 3'd1, 32'h43, 32'h0, 1'b1, 32'h0, 1'b1, 1, 0, 32'h0};
`else
    vecs[7]  = '{1'b0, 3'd1, 32'h43, 32'h0, 1'b0, 32'h00001299, 1'b0, 3, 0, 32'h0};
`endif
    vecs[8]  = '{1'b1, 3'd1, 32'h46, 32'h1234CAFE, 1'b1, 32'h0, 1'b0, 4, 1, 32'hCAFE0000};
    vecs[9]  = '{1'b0, 3'd1, 32'h46, 32'h0, 1'b0, 32'hFFFFCAFE, 1'b0, 3, 0, 32'h0};
    vecs[10] = '{1'b0, 3'd0, 32'h47, 32'h0, 1'b0, 32'hFFFFFFCA, 1'b0, 3, 0, 32'h0};
    vecs[11] = '{1'b0, 3'd3, 32'h40, 32'h0, 1'b1, 32'h0, 1'b1, 1, 0, 32'h0};
    vecs[12] = '{1'b1, 3'd3, 32'h40, 32'h55, 1'b1, 32'h0, 1'b1, 1, 0, 32'h0};
    vecs[13] = '{1'b0, 3'd7, 32'h40, 32'h0, 1'b1, 32'h0, 1'b1, 1, 0, 32'h0};
    vecs[14] = '{1'b1, 3'd0, 32'h44, 32'h00000077, 1'b1, 32'h0, 1'b0, 4, 1, 32'hCAFE0077};
    vecs[15] = '{1'b0, 3'd4, 32'h44, 32'h0, 1'b0, 32'h00000077, 1'b0, 3, 0, 32'h0};

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_rw", bus.mem_rw, 1'b1);
    preload = 1'b0;
    resetn  = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // SW with a second request held valid while busy
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_SW;
    bus.req_addr   = 32'h44;
    bus.req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_LW;
    bus.req_wdata  = 32'h0;
    wait_rsp(lat, nwr, wd, busy);
    chk("sw_lat", lat, 2);
    chk("sw_err", bus.rsp_err, 1'b0);
    chk("sw_nwr", nwr, 1);
    chk("sw_wword", wd, 32'hDEADBEEF);
    chk("sw_busy_rdy", busy, 0);
    chk("sw_ready_in_done", bus.req_ready, 1'b0);
    chk("sw_rdata_held", bus.rsp_rdata, last_exp);
    @(negedge clk);
    chk("queued_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_rsp(lat, nwr, wd, busy);
    chk("queued_lat", lat, 3);
    chk("queued_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("queued_nwr", nwr, 0);
    last_exp = 32'hDEADBEEF;

    // SH aborted by reset during RD_WAIT
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_SH;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'h00005555;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_mem_rw", bus.mem_rw, 1'b1);
    chk("abort_ready", bus.req_ready, 1'b1);
    chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
    chk("abort_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    wr_seen = 0;
    rsp_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!bus.mem_rw) wr_seen++;
      if (bus.rsp_valid) rsp_seen++;
    end
    chk("abort_writes", wr_seen, 0);
    chk("abort_rsp", rsp_seen, 0);
    chk("abort_ready_after", bus.req_ready, 1'b1);
    chk("abort_mem_word", mem[16], 32'h1299AABB);
    last_exp = 32'h0;
    run_vec('{1'b0, 3'd2, 32'h40, 32'h0, 1'b0, 32'h1299AABB, 1'b0, 3, 0, 32'h0}, 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
